mem_access_stage: RTL and testbench

Memory-access (MEM) stage of the pipelined processor. It sits between the EX/MEM latch and the MEM/WB latch and holds the word-organised data memory. It executes byte/half/word loads and stores, forwards write-back control signals unchanged, and provides a ready/valid dump port. The debug unit uses that port to stream the memory contents out.

---
 rtl/mem_access_stage_if.sv | 46 ++++
 rtl/mem_access_stage.sv | 147 ++++++++++++++
 tb/tb_mem_access_stage.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Bus bundle between the EX/MEM latch, the MEM stage and the debug dump consumer.
// master drives the stage inputs; slave is the MEM stage itself.
interface mem_access_stage_if #(
   parameter int NB_DATA      = 32,
   parameter int NB_WORD_ADDR = 5
);
   logic [1:0]              i_pipeline_mode;
   logic                    i_run_clockcycle;
   logic                    i_mem_read;
   logic                    i_mem_write;
   logic [2:0]              i_funct3;
   logic [NB_DATA-1:0]      i_alu_result;
   logic [NB_DATA-1:0]      i_write_data;
   logic                    i_WB;
   logic [4:0]              i_instruct_11_7;
   logic                    i_EOF_flag;
   logic [NB_DATA-1:0]      o_read_data;
   logic [NB_DATA-1:0]      o_alu_result;
   logic                    o_WB;
   logic [4:0]              o_instruct_11_7;
   logic                    o_EOF_flag;
   logic                    o_misaligned;
   logic                    i_dump_start;
   logic                    i_dump_ready;
   logic                    o_dump_valid;
   logic [NB_WORD_ADDR-1:0] o_dump_addr;
   logic [NB_DATA-1:0]      o_dump_data;
   logic                    o_dump_done;
   logic                    o_busy;

   modport master (
      output i_pipeline_mode, i_run_clockcycle, i_mem_read, i_mem_write, i_funct3,
             i_alu_result, i_write_data, i_WB, i_instruct_11_7, i_EOF_flag,
             i_dump_start, i_dump_ready,
      input  o_read_data, o_alu_result, o_WB, o_instruct_11_7, o_EOF_flag,
             o_misaligned, o_dump_valid, o_dump_addr, o_dump_data, o_dump_done, o_busy
   );

   modport slave (
      input  i_pipeline_mode, i_run_clockcycle, i_mem_read, i_mem_write, i_funct3,
             i_alu_result, i_write_data, i_WB, i_instruct_11_7, i_EOF_flag,
             i_dump_start, i_dump_ready,
      output o_read_data, o_alu_result, o_WB, o_instruct_11_7, o_EOF_flag,
             o_misaligned, o_dump_valid, o_dump_addr, o_dump_data, o_dump_done, o_busy
   );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: word-organised data memory with byte/half/word loads and stores,
// write-back control pass-through and a ready/valid memory dump port.
module mem_access_stage #(
   parameter int NB_DATA      = 32,
   parameter int NB_WORD_ADDR = 5
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   mem_access_stage_if.slave  bus
);
   localparam int DEPTH  = 1 << NB_WORD_ADDR;
   localparam int NLANES = NB_DATA / 8;

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} dump_state_t;

   dump_state_t             state_q;
   logic [NB_WORD_ADDR-1:0] idx_q;
   logic [NB_DATA-1:0]      mem_q [DEPTH];

   logic                    advance;
   logic                    busy;
   logic [NB_WORD_ADDR-1:0] word_idx;
   logic [1:0]              lane;
   logic [2:0]              f3;
   logic                    load_ok;
   logic                    store_ok;
   logic                    half_bad;
   logic                    word_bad;
   logic                    misaligned;
   logic                    store_en;
   logic [NB_DATA-1:0]      rd_word;
   logic [7:0]              rd_byte;
   logic [15:0]             rd_half;
   logic [NB_DATA-1:0]      read_data;
   logic [NLANES-1:0]       wr_be;
   logic [NB_DATA-1:0]      wr_src;
   logic [NB_DATA-1:0]      wr_word;

   assign f3       = bus.i_funct3;
   assign word_idx = bus.i_alu_result[NB_WORD_ADDR+1:2];
   assign lane     = bus.i_alu_result[1:0];
   assign advance  = (bus.i_pipeline_mode == 2'b01) |
                     ((bus.i_pipeline_mode == 2'b11) & bus.i_run_clockcycle);
   assign busy     = (state_q != ST_IDLE);

   // Legal encodings: loads LB/LH/LW/LBU/LHU, stores SB/SH/SW.
   assign load_ok    = (f3 == 3'b000) | (f3 == 3'b001) | (f3 == 3'b010) |
                       (f3 == 3'b100) | (f3 == 3'b101);
   assign store_ok   = ~f3[2] & (f3[1:0] != 2'b11);
   assign half_bad   = (f3[1:0] == 2'b01) & lane[0];
   assign word_bad   = (f3[1:0] == 2'b10) & (lane != 2'b00);
   assign misaligned = (bus.i_mem_read | bus.i_mem_write) &
                       (half_bad | word_bad |
                        (bus.i_mem_read & ~load_ok) | (bus.i_mem_write & ~store_ok));
   assign store_en   = bus.i_mem_write & ~misaligned & advance & ~busy;

   // Reads always see the pre-edge contents, so a same-cycle store shows old data.
   assign rd_word = mem_q[word_idx];
   assign rd_byte = rd_word[{lane, 3'b000} +: 8];
   assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

   // Load extraction and sign/zero extension.
   always_comb begin
      read_data = '0;
      if (bus.i_mem_read && !misaligned) begin
         case (f3)
            3'b000:  read_data = {{(NB_DATA-8){rd_byte[7]}}, rd_byte};
            3'b100:  read_data = {{(NB_DATA-8){1'b0}}, rd_byte};
            3'b001:  read_data = {{(NB_DATA-16){rd_half[15]}}, rd_half};
            3'b101:  read_data = {{(NB_DATA-16){1'b0}}, rd_half};
            3'b010:  read_data = rd_word;
            default: read_data = '0;
         endcase
      end
   end

   // Store lane enables; the source data is replicated so each lane sees its slice.
   always_comb begin
      wr_be  = '0;
      wr_src = bus.i_write_data;
      case (f3[1:0])
         2'b00: begin
            wr_be  = NLANES'(1) << lane;
            wr_src = {NLANES{bus.i_write_data[7:0]}};
         end
         2'b01: begin
            wr_be  = lane[1] ? 4'b1100 : 4'b0011;
            wr_src = {(NLANES/2){bus.i_write_data[15:0]}};
         end
         2'b10:   wr_be = '1;
         default: wr_be = '0;
      endcase
   end

   // Merge enabled lanes into the current word so unwritten lanes are preserved.
   generate
      for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
         assign wr_word[gi*8 +: 8] = wr_be[gi] ? wr_src[gi*8 +: 8] : rd_word[gi*8 +: 8];
      end
   endgenerate

   // Data memory: cleared on reset, one word written per committed store.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (store_en) begin
         mem_q[word_idx] <= wr_word;
      end
   end

   // Dump sequencer: stream every word in index order, then pulse done for one cycle.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.i_dump_start) begin
                  state_q <= ST_SEND;
                  idx_q   <= '0;
               end
            end
            ST_SEND: begin
               if (bus.i_dump_ready) begin
                  idx_q <= idx_q + 1'b1;
                  if (idx_q == {NB_WORD_ADDR{1'b1}}) state_q <= ST_DONE;
               end
            end
            ST_DONE:  state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_read_data     = read_data;
   assign bus.o_misaligned    = misaligned;
   assign bus.o_alu_result    = bus.i_alu_result;
   assign bus.o_WB            = bus.i_WB;
   assign bus.o_instruct_11_7 = bus.i_instruct_11_7;
   assign bus.o_EOF_flag      = bus.i_EOF_flag;
   assign bus.o_dump_valid    = (state_q == ST_SEND);
   assign bus.o_dump_addr     = idx_q;
   assign bus.o_dump_data     = (state_q == ST_SEND) ? mem_q[idx_q] : '0;
   assign bus.o_dump_done     = (state_q == ST_DONE);
   assign bus.o_busy          = busy;
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage against a byte-addressed reference model.
module tb_mem_access_stage;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   bit   dump_active = 1'b0;
   logic [7:0]  ref_bytes [128];
   logic        wb_v;
   logic [4:0]  rd_v;
   logic        eof_v;

   mem_access_stage_if bus ();

   mem_access_stage dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int ref_size(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic logic ref_illegal(input logic rd, input logic wr,
                                        input logic [2:0] f3, input logic [31:0] a);
      int n;
      if (!(rd || wr)) return 1'b0;
      if (wr && f3 > 3'd2) return 1'b1;
      if (rd && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5))
         return 1'b1;
      n = ref_size(f3);
      return (int'(a[1:0]) % n) != 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      int n;
      int base;
      logic [31:0] v;
      n    = ref_size(f3);
      base = int'(a[6:0]);
      v    = 32'd0;
      if (n == 0) return 32'd0;
      for (int k = 0; k < n; k++) v = v | (32'(ref_bytes[base + k]) << (8 * k));
      if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   function automatic logic ref_advance();
      return (bus.i_pipeline_mode == 2'b01) ||
             (bus.i_pipeline_mode == 2'b11 && bus.i_run_clockcycle);
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int n;
      int base;
      n    = ref_size(f3);
      base = int'(a[6:0]);
      for (int k = 0; k < n; k++) ref_bytes[base + k] = 8'(d >> (8 * k));
   endtask

   task automatic ref_clear();
      for (int i = 0; i < 128; i++) ref_bytes[i] = 8'h00;
   endtask

   // ---------------- drivers ----------------
   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      wb_v  = 1'($urandom);
      rd_v  = 5'($urandom);
      eof_v = 1'($urandom);
      bus.i_mem_read      = rd;
      bus.i_mem_write     = wr;
      bus.i_funct3        = f3;
      bus.i_alu_result    = a;
      bus.i_write_data    = d;
      bus.i_WB            = wb_v;
      bus.i_instruct_11_7 = rd_v;
      bus.i_EOF_flag      = eof_v;
   endtask

   task automatic step_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      bit commit;
      drive(1'b0, 1'b1, f3, a, d);
      commit = ref_advance() && !ref_illegal(1'b0, 1'b1, f3, a) && !dump_active;
      @(posedge clk); #1;
      if (commit) ref_store(f3, a, d);
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      ref_clear();
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      #3;
      checks++; if (bus.o_dump_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.o_dump_valid); end
      checks++; if (bus.o_dump_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.o_dump_done); end
      checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
      checks++; if (bus.o_dump_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.o_dump_addr); end
      checks++; if (bus.o_dump_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.o_dump_data); end
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 1'b0, 3'b010, 32'(i * 4), 32'd0);
         #1;
         checks++;
         if (bus.o_read_data !== 32'd0) begin
            errors++; $display("FAIL reset_mem word %0d: got %h expected 0", i, bus.o_read_data);
         end
      end
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_plan_loads();
      logic [2:0]  f3_t  [4];
      logic [31:0] adr_t [4];
      logic [31:0] exp_t [4];
      f3_t  = '{3'b010, 3'b000, 3'b100, 3'b101};
      adr_t = '{32'h4, 32'h7, 32'h7, 32'h4};
      exp_t = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'h0000BEEF};
      step_store(3'b010, 32'h4, 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, f3_t[i], adr_t[i], 32'd0);
         #1;
         checks++;
         if (bus.o_read_data !== exp_t[i] || bus.o_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL plan_load f3=%0d addr=%h: got %h mis=%b expected %h mis=0",
                     f3_t[i], adr_t[i], bus.o_read_data, bus.o_misaligned, exp_t[i]);
         end
      end
      step_store(3'b000, 32'h5, 32'h00000012);
      drive(1'b1, 1'b0, 3'b010, 32'h4, 32'd0); #1;
      checks++; if (bus.o_read_data !== 32'hDEAD12EF) begin errors++; $display("FAIL plan_sb: got %h expected deadbeef->dead12ef", bus.o_read_data); end
      step_store(3'b001, 32'h6, 32'h00008001);
      drive(1'b1, 1'b0, 3'b001, 32'h6, 32'd0); #1;
      checks++; if (bus.o_read_data !== 32'hFFFF8001) begin errors++; $display("FAIL plan_sh: got %h expected ffff8001", bus.o_read_data); end
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   task automatic test_misaligned();
      drive(1'b0, 1'b1, 3'b010, 32'h6, 32'hCAFEF00D); #1;
      checks++; if (bus.o_misaligned !== 1'b1) begin errors++; $display("FAIL mis_sw: got %b expected 1", bus.o_misaligned); end
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 3'b010, 32'h4, 32'd0); #1;
      checks++; if (bus.o_read_data !== 32'h800112EF) begin errors++; $display("FAIL mis_sw_nowrite: got %h expected 800112ef", bus.o_read_data); end
      drive(1'b1, 1'b0, 3'b001, 32'h3, 32'd0); #1;
      checks++; if (bus.o_misaligned !== 1'b1 || bus.o_read_data !== 32'd0) begin errors++; $display("FAIL mis_lh: got mis=%b data=%h expected mis=1 data=0", bus.o_misaligned, bus.o_read_data); end
      drive(1'b1, 1'b0, 3'b011, 32'h4, 32'd0); #1;
      checks++; if (bus.o_misaligned !== 1'b1 || bus.o_read_data !== 32'd0) begin errors++; $display("FAIL mis_f3_011: got mis=%b data=%h expected mis=1 data=0", bus.o_misaligned, bus.o_read_data); end
      drive(1'b0, 1'b1, 3'b100, 32'h4, 32'd0); #1;
      checks++; if (bus.o_misaligned !== 1'b1) begin errors++; $display("FAIL mis_store_f3_100: got %b expected 1", bus.o_misaligned); end
      drive(1'b0, 1'b0, 3'b001, 32'h3, 32'd0); #1;
      checks++; if (bus.o_misaligned !== 1'b0) begin errors++; $display("FAIL mis_no_access: got %b expected 0", bus.o_misaligned); end
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   task automatic test_rw_same();
      drive(1'b1, 1'b1, 3'b010, 32'h4, 32'h11223344); #1;
      checks++; if (bus.o_read_data !== 32'h800112EF) begin errors++; $display("FAIL rw_prewrite: got %h expected 800112ef", bus.o_read_data); end
      @(posedge clk); #1;
      ref_store(3'b010, 32'h4, 32'h11223344);
      drive(1'b1, 1'b0, 3'b010, 32'h4, 32'd0); #1;
      checks++; if (bus.o_read_data !== 32'h11223344) begin errors++; $display("FAIL rw_postwrite: got %h expected 11223344", bus.o_read_data); end
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   task automatic test_mode();
      bus.i_pipeline_mode = 2'b11; bus.i_run_clockcycle = 1'b0;
      step_store(3'b010, 32'h8, 32'h55);
      drive(1'b1, 1'b0, 3'b010, 32'h8, 32'd0); #1;
      checks++; if (bus.o_read_data !== 32'h0) begin errors++; $display("FAIL mode_step_norun: got %h expected 0", bus.o_read_data); end
      bus.i_run_clockcycle = 1'b1;
      step_store(3'b010, 32'h8, 32'h55);
      drive(1'b1, 1'b0, 3'b010, 32'h8, 32'd0); #1;
      checks++; if (bus.o_read_data !== 32'h55) begin errors++; $display("FAIL mode_step_run: got %h expected 55", bus.o_read_data); end
      bus.i_pipeline_mode = 2'b00;
      step_store(3'b010, 32'h8, 32'h77);
      drive(1'b1, 1'b0, 3'b010, 32'h8, 32'd0); #1;
      checks++; if (bus.o_read_data !== 32'h55) begin errors++; $display("FAIL mode_frozen00: got %h expected 55", bus.o_read_data); end
      bus.i_pipeline_mode = 2'b10;
      step_store(3'b010, 32'h8, 32'h99);
      drive(1'b1, 1'b0, 3'b010, 32'h8, 32'd0); #1;
      checks++; if (bus.o_read_data !== 32'h55) begin errors++; $display("FAIL mode_frozen10: got %h expected 55", bus.o_read_data); end
      bus.i_pipeline_mode = 2'b01; bus.i_run_clockcycle = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   task automatic test_random();
      logic rd, wr, exp_mis;
      logic [2:0]  f3;
      logic [31:0] a, d, exp_rd;
      for (int it = 0; it < 300; it++) begin
         rd = 1'($urandom); wr = 1'($urandom);
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
         d  = $urandom;
         case ($urandom_range(0, 5))
            0:       begin bus.i_pipeline_mode = 2'b11; bus.i_run_clockcycle = 1'($urandom); end
            1:       bus.i_pipeline_mode = 2'b00;
            default: begin bus.i_pipeline_mode = 2'b01; bus.i_run_clockcycle = 1'b0; end
         endcase
         drive(rd, wr, f3, a, d);
         exp_mis = ref_illegal(rd, wr, f3, a);
         exp_rd  = (rd && !exp_mis) ? ref_load(f3, a) : 32'd0;
         #1;
         checks++;
         if (bus.o_misaligned !== exp_mis || bus.o_read_data !== exp_rd) begin
            errors++;
            $display("FAIL rand_access #%0d rd=%b wr=%b f3=%0d a=%h: got mis=%b data=%h expected mis=%b data=%h",
                     it, rd, wr, f3, a, bus.o_misaligned, bus.o_read_data, exp_mis, exp_rd);
         end
         checks++;
         if (bus.o_alu_result !== a || bus.o_WB !== wb_v || bus.o_instruct_11_7 !== rd_v ||
             bus.o_EOF_flag !== eof_v) begin
            errors++;
            $display("FAIL rand_passthru #%0d: got %h/%b/%0d/%b expected %h/%b/%0d/%b", it,
                     bus.o_alu_result, bus.o_WB, bus.o_instruct_11_7, bus.o_EOF_flag,
                     a, wb_v, rd_v, eof_v);
         end
         if (wr && !exp_mis && ref_advance()) begin
            @(posedge clk); #1;
            ref_store(f3, a, d);
         end else begin
            @(posedge clk); #1;
         end
      end
      bus.i_pipeline_mode = 2'b01; bus.i_run_clockcycle = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   task automatic test_dump();
      int exp_idx = 0;
      int done_cnt = 0;
      for (int i = 0; i < 32; i++) step_store(3'b010, 32'(i * 4), 32'(i + 1));
      bus.i_dump_ready = 1'b0; bus.i_dump_start = 1'b1;
      @(posedge clk); #1;
      bus.i_dump_start = 1'b0;
      dump_active = 1'b1;
      for (int cyc = 0; cyc < 200 && done_cnt == 0; cyc++) begin
         bus.i_dump_ready = cyc[0];
         bus.i_dump_start = (cyc == 8);
         if (cyc == 6) drive(1'b0, 1'b1, 3'b010, 32'h7C, 32'hFFFFFFFF);
         else          drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
         #1;
         if (bus.o_dump_valid) begin
            checks++;
            if (exp_idx > 31 || bus.o_dump_addr !== 5'(exp_idx) ||
                bus.o_dump_data !== ref_load(3'b010, 32'(exp_idx * 4)) || bus.o_busy !== 1'b1) begin
               errors++;
               $display("FAIL dump_word cyc=%0d: got addr=%0d data=%h busy=%b expected addr=%0d data=%h busy=1",
                        cyc, bus.o_dump_addr, bus.o_dump_data, bus.o_busy, exp_idx,
                        ref_load(3'b010, 32'(exp_idx * 4)));
            end
            if (bus.i_dump_ready) exp_idx++;
         end else if (!bus.o_dump_done) begin
            checks++; errors++;
            $display("FAIL dump_gap cyc=%0d: got valid=0 done=0 expected valid or done", cyc);
         end
         if (bus.o_dump_done) begin
            done_cnt++;
            checks++;
            if (exp_idx != 32) begin errors++; $display("FAIL dump_done_early: got %0d words expected 32", exp_idx); end
         end
         @(posedge clk); #1;
      end
      bus.i_dump_ready = 1'b0;
      dump_active = 1'b0;
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL dump_timeout: got %0d done pulses expected 1", done_cnt); end
      checks++;
      if (bus.o_dump_valid !== 1'b0 || bus.o_dump_done !== 1'b0 || bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL dump_idle: got valid=%b done=%b busy=%b expected 0/0/0",
                  bus.o_dump_valid, bus.o_dump_done, bus.o_busy);
      end
      drive(1'b1, 1'b0, 3'b010, 32'h7C, 32'd0); #1;
      checks++; if (bus.o_read_data !== 32'd32) begin errors++; $display("FAIL dump_store_blocked: got %h expected 20", bus.o_read_data); end
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   task automatic test_back_to_back();
      bus.i_dump_ready = 1'b1; bus.i_dump_start = 1'b1;
      @(posedge clk); #1;
      bus.i_dump_start = 1'b0;
      for (int n = 1; n <= 34; n++) begin
         checks++;
         if (bus.o_dump_valid !== (n <= 32) || bus.o_dump_done !== (n == 33) ||
             bus.o_busy !== (n <= 33) || (n <= 32 && bus.o_dump_addr !== 5'(n - 1))) begin
            errors++;
            $display("FAIL b2b_timing t+%0d: got valid=%b done=%b busy=%b addr=%0d expected valid=%b done=%b busy=%b addr=%0d",
                     n, bus.o_dump_valid, bus.o_dump_done, bus.o_busy, bus.o_dump_addr,
                     (n <= 32), (n == 33), (n <= 33), (n - 1) % 32);
         end
         @(posedge clk); #1;
      end
      bus.i_dump_ready = 1'b0;
   endtask

   task automatic test_reset_mid_dump();
      for (int i = 0; i < 8; i++) step_store(3'b010, 32'($urandom_range(0, 31) * 4), $urandom | 32'h1);
      bus.i_dump_ready = 1'b1; bus.i_dump_start = 1'b1;
      @(posedge clk); #1;
      bus.i_dump_start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      #1 rst_n = 1'b0;
      #1;
      ref_clear();
      checks++;
      if (bus.o_dump_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_dump_addr !== 5'd0 ||
          bus.o_dump_data !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid_dump: got valid=%b busy=%b addr=%0d data=%h expected 0",
                  bus.o_dump_valid, bus.o_busy, bus.o_dump_addr, bus.o_dump_data);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.o_dump_done !== 1'b0 || bus.o_dump_valid !== 1'b0) begin
            errors++; $display("FAIL rst_no_done cyc %0d: got done=%b valid=%b expected 0/0", c, bus.o_dump_done, bus.o_dump_valid);
         end
      end
      bus.i_dump_ready = 1'b0;
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 1'b0, 3'b010, 32'(i * 4), 32'd0); #1;
         checks++;
         if (bus.o_read_data !== ref_load(3'b010, 32'(i * 4))) begin
            errors++; $display("FAIL rst_mem_clear word %0d: got %h expected 0", i, bus.o_read_data);
         end
      end
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   initial begin
      rst_n                = 1'b0;
      bus.i_pipeline_mode  = 2'b01;
      bus.i_run_clockcycle = 1'b0;
      bus.i_dump_start     = 1'b0;
      bus.i_dump_ready     = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      test_reset();
      test_plan_loads();
      test_misaligned();
      test_rw_same();
      test_mode();
      test_random();
      test_dump();
      test_back_to_back();
      test_reset_mid_dump();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
